// File: rtl/uart_rx_line.sv
// uart_rx_line: 8N1 UART receiver feeding a newline-terminated line buffer.
// The clock is RST_clk; rst is an asynchronous, active-high reset.
module uart_rx_line #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD = 115200,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          RST_clk,
  input  logic          rst,
  input  logic          uart_rx,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  output logic          frame_err,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          line_ready,
  output logic [AW:0]   line_len,
  input  logic          line_ack,
  output logic          overflow
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] BIT_END = CW'(CPB - 1);
  localparam logic [CW-1:0] MID = CW'(CPB / 2 - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic [AW:0]   wptr;
  logic [7:0]    mem [DEPTH];
  logic          rx;
  logic          bit_done;
  logic          wr;

  assign rx = sync[1];
  assign bit_done = cnt == BIT_END;
  assign wr = rx_valid && !line_ready && wptr != FULL;
  assign rd_data = mem[rd_addr];

  always_ff @(posedge RST_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sync <= 2'b11;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync <= {sync[0], uart_rx};
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      cnt <= cnt + CW'(1);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx) state <= START;
        end
        START: if (cnt == MID) begin
          cnt <= '0;
          idx <= '0;
          state <= rx ? IDLE : DATA;
        end
        DATA: if (bit_done) begin
          cnt <= '0;
          shift <= {rx, shift[7:1]};
          idx <= idx + 3'd1;
          if (idx == 3'd7) state <= STOP;
        end
        STOP: if (bit_done) begin
          cnt <= '0;
          state <= IDLE;
          if (rx) begin
            rx_data <= shift;
            rx_valid <= 1'b1;
          end else frame_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A full buffer keeps wptr at DEPTH so a late newline still closes the line.
  always_ff @(posedge RST_clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      line_ready <= 1'b0;
      line_len <= '0;
      overflow <= 1'b0;
    end else if (line_ack && line_ready) begin
      line_ready <= 1'b0;
      wptr <= '0;
      overflow <= rx_valid;
    end else if (rx_valid) begin
      if (line_ready) overflow <= 1'b1;
      else if (wptr == FULL) begin
        if (rx_data == 8'h0A) begin
          line_ready <= 1'b1;
          line_len <= FULL;
        end else overflow <= 1'b1;
      end else begin
        wptr <= wptr + ONE;
        if (rx_data == 8'h0A) begin
          line_ready <= 1'b1;
          line_len <= wptr + ONE;
        end
      end
    end
  end

  always_ff @(posedge RST_clk) begin
    if (wr) mem[wptr[AW-1:0]] <= rx_data;
  end
endmodule

// File: tb/tb_uart_rx_line.sv
// tb_uart_rx_line: directed bench for the UART line receiver at 16 clocks per bit.
module tb_uart_rx_line;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       line_ack = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic [7:0] rd_data;
  logic       line_ready;
  logic [4:0] line_len;
  logic       overflow;
  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int fcnt = 0;
  int cyc = 0;
  int vcyc = 0;
  int v0, f0, st;
  bit seen;

  uart_rx_line #(.CLK_FREQ(16), .BAUD(1), .DEPTH(16)) dut (
    .RST_clk(clk), .rst(rst), .uart_rx(uart_rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .rd_addr(rd_addr),
    .rd_data(rd_data), .line_ready(line_ready), .line_len(line_len),
    .line_ack(line_ack), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (rx_valid) begin
      vcnt++;
      vcyc = cyc;
    end
    if (frame_err) fcnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(16);
    end
    uart_rx = stop;
    tick(16);
    uart_rx = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic ack();
    line_ack = 1'b1;
    tick(1);
    line_ack = 1'b0;
    tick(1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, rx_data, 8'h00);
    chk({tag, "_valid"}, rx_valid, 1'b0);
    chk({tag, "_ferr"}, frame_err, 1'b0);
    chk({tag, "_ready"}, line_ready, 1'b0);
    chk({tag, "_len"}, line_len, 5'd0);
    chk({tag, "_ovf"}, overflow, 1'b0);
  endtask

  initial begin
    tick(3);
    chk_reset_vals("rst");
    rst = 1'b0;
    tick(4);

    v0 = vcnt;
    f0 = fcnt;
    st = cyc;
    send(8'h55, 1'b1);
    tick(4);
    chk("b55_data", rx_data, 8'h55);
    chk("b55_pulses", vcnt - v0, 1);
    chk("b55_ferr", fcnt - f0, 0);
    chk("b55_latency_ok", (vcyc - st) <= 156, 1'b1);

    do_reset();
    send(8'h68, 1'b1);
    send(8'h69, 1'b1);
    send(8'h0A, 1'b1);
    tick(4);
    chk("hi_ready", line_ready, 1'b1);
    chk("hi_len", line_len, 5'd3);
    rd_addr = 4'd0;
    #1 chk("hi_rd0", rd_data, 8'h68);
    rd_addr = 4'd1;
    #1 chk("hi_rd1", rd_data, 8'h69);
    rd_addr = 4'd2;
    #1 chk("hi_rd2", rd_data, 8'h0A);
    ack();
    chk("hi_ack_ready", line_ready, 1'b0);
    chk("hi_ack_ovf", overflow, 1'b0);
    rd_addr = 4'd0;
    #1 chk("hi_hold_rd0", rd_data, 8'h68);

    v0 = vcnt;
    f0 = fcnt;
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(40);
    chk("glitch_valid", vcnt - v0, 0);
    chk("glitch_ferr", fcnt - f0, 0);
    send(8'hC3, 1'b1);
    tick(4);
    chk("glitch_next_data", rx_data, 8'hC3);
    chk("glitch_next_pulses", vcnt - v0, 1);

    do_reset();
    v0 = vcnt;
    f0 = fcnt;
    send(8'hA5, 1'b0);
    tick(40);
    chk("ferr_pulses", fcnt - f0, 1);
    chk("ferr_valid", vcnt - v0, 0);
    chk("ferr_data", rx_data, 8'h00);
    send(8'h0A, 1'b1);
    tick(4);
    chk("ferr_wptr_len", line_len, 5'd1);
    chk("ferr_nl_ready", line_ready, 1'b1);

    do_reset();
    for (int i = 0; i < 17; i++) send(8'h41, 1'b1);
    tick(4);
    chk("ovf_17_ovf", overflow, 1'b1);
    chk("ovf_17_ready", line_ready, 1'b0);
    send(8'h0A, 1'b1);
    tick(4);
    chk("ovf_ready", line_ready, 1'b1);
    chk("ovf_len", line_len, 5'd16);
    rd_addr = 4'd15;
    #1 chk("ovf_rd15", rd_data, 8'h41);
    v0 = vcnt;
    send(8'h42, 1'b1);
    tick(4);
    chk("held_pulse", vcnt - v0, 1);
    chk("held_ready", line_ready, 1'b1);
    chk("held_len", line_len, 5'd16);
    chk("held_ovf", overflow, 1'b1);
    rd_addr = 4'd0;
    #1 chk("held_rd0", rd_data, 8'h41);

    seen = 1'b0;
    fork
      send(8'h42, 1'b1);
      begin
        for (int k = 0; k < 300 && !seen; k++) begin
          @(negedge clk);
          if (rx_valid) begin
            seen = 1'b1;
            line_ack = 1'b1;
          end
        end
        @(negedge clk);
        line_ack = 1'b0;
      end
    join
    tick(4);
    chk("coll_seen", seen, 1'b1);
    chk("coll_ready", line_ready, 1'b0);
    chk("coll_ovf", overflow, 1'b1);
    #1 chk("coll_rd0", rd_data, 8'h41);
    send(8'h0A, 1'b1);
    tick(4);
    chk("coll_wptr_len", line_len, 5'd1);
    #1 chk("coll_nl_rd0", rd_data, 8'h0A);
    ack();
    chk("coll_ack_ovf", overflow, 1'b0);

    v0 = vcnt;
    f0 = fcnt;
    uart_rx = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      uart_rx = 1'b1;
      tick(16);
    end
    uart_rx = 1'b0;
    tick(8);
    rst = 1'b1;
    tick(2);
    uart_rx = 1'b1;
    chk_reset_vals("mid");
    rst = 1'b0;
    tick(40);
    chk("mid_no_valid", vcnt - v0, 0);
    chk("mid_no_ferr", fcnt - f0, 0);
    send(8'h3C, 1'b1);
    tick(4);
    chk("mid_next_data", rx_data, 8'h3C);
    chk("mid_next_pulses", vcnt - v0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
